// File: rtl/cpu_pkg.sv
// Shared CPU definitions: extender modes, opcodes of interest, fetch FSM states.
package cpu_pkg;

    localparam logic [1:0] EXT_ZERO    = 2'b00;
    localparam logic [1:0] EXT_SIGNED  = 2'b01;
    localparam logic [1:0] EXT_HIGHPOS = 2'b10;

    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI = 6'h0E;
    localparam logic [5:0] OP_LUI  = 6'h0F;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    typedef enum logic [1:0] {
        RST,
        FETCH,
        HOLD
    } ifu_state_t;

    // Logical immediates are zero-extended, lui places the immediate high.
    function automatic logic [1:0] extOpDecode(input logic [5:0] opcode);
        case (opcode)
            OP_ANDI, OP_ORI, OP_XORI: extOpDecode = EXT_ZERO;
            OP_LUI:                   extOpDecode = EXT_HIGHPOS;
            default:                  extOpDecode = EXT_SIGNED;
        endcase
    endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction-memory fetch handshake between the fetch unit and instruction memory.
interface ifetch_unit_if;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic [31:0] ImemRdata;
    logic        ImemRvalid;

    modport master (output ImemReq, ImemAddr, input ImemRdata, ImemRvalid);
    modport slave  (input ImemReq, ImemAddr, output ImemRdata, ImemRvalid);
endinterface

// File: rtl/ifetch_unit_next_pc.sv
// Combinational next-PC selection (jr > j > taken branch > sequential) and jr alignment check.
module next_pc_logic
    import cpu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [25:0] jumpIndex,
    input  logic        jumpReg,
    input  logic        jump,
    input  logic        branchTaken,
    input  logic [29:0] branchOff,
    input  logic [31:0] jrAddr,
    output logic [31:0] pcPlus4,
    output logic [31:0] nextPc,
    output logic        jrMisaligned
);

    logic [31:0] branchTarget;

    assign pcPlus4      = pc + 32'd4;
    assign branchTarget = pcPlus4 + {branchOff, 2'b00};
    assign jrMisaligned = jumpReg && (jrAddr[1:0] != 2'b00);

    always_comb begin
        nextPc = pcPlus4;
        if (jumpReg)
            nextPc = {jrAddr[31:2], 2'b00};
        else if (jump)
            nextPc = {pcPlus4[31:28], jumpIndex, 2'b00};
        else if (branchTaken)
            nextPc = branchTarget;
    end

endmodule

// File: rtl/ifetch_unit.sv
// Fetch stage: PC and instruction registers plus the RST/FETCH/HOLD sequencer.
module ifetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    ifetch_unit_if.master       imem,
    output logic [31:0]         Instr,
    output logic                InstrValid,
    output logic [31:0]         PC,
    output logic [31:0]         PCPlus4,
    output logic [15:0]         Imm16,
    output logic [1:0]          ExtOp,
    input  logic                ExDone,
    input  logic                BranchTaken,
    input  logic [31:0]         BranchOff,
    input  logic                Jump,
    input  logic                JumpReg,
    input  logic [31:0]         JrAddr,
    output logic                AddrErr
);

    ifu_state_t  state;
    logic        imemReq;
    logic [31:0] nextPc;
    logic        jrMisaligned;
    logic        unusedOffHi;

    // The offset is shifted left by two, so its top two bits fall off.
    assign unusedOffHi = ^BranchOff[31:30];

    next_pc_logic uNextPc (
        .pc           (PC),
        .jumpIndex    (Instr[25:0]),
        .jumpReg      (JumpReg),
        .jump         (Jump),
        .branchTaken  (BranchTaken),
        .branchOff    (BranchOff[29:0]),
        .jrAddr       (JrAddr),
        .pcPlus4      (PCPlus4),
        .nextPc       (nextPc),
        .jrMisaligned (jrMisaligned)
    );

    assign imem.ImemReq  = imemReq;
    assign imem.ImemAddr = PC;
    assign Imm16         = Instr[15:0];
    assign ExtOp         = extOpDecode(Instr[31:26]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= RST;
            PC         <= RESET_PC;
            Instr      <= '0;
            InstrValid <= 1'b0;
            imemReq    <= 1'b0;
            AddrErr    <= 1'b0;
        end else begin
            AddrErr <= 1'b0;
            case (state)
                RST: begin
                    state   <= FETCH;
                    imemReq <= 1'b1;
                end
                FETCH: begin
                    if (imem.ImemRvalid) begin
                        Instr      <= imem.ImemRdata;
                        InstrValid <= 1'b1;
                        imemReq    <= 1'b0;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (ExDone) begin
                        PC         <= nextPc;
                        InstrValid <= 1'b0;
                        imemReq    <= 1'b1;
                        AddrErr    <= jrMisaligned;
                        state      <= FETCH;
                    end
                end
                default: state <= RST;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: reset, wait-state fetch, decode, next-PC table, spurious inputs, mid-fetch reset.
module tb_ifetch_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] Instr, PC, PCPlus4, BranchOff, JrAddr;
    logic        InstrValid, ExDone, BranchTaken, Jump, JumpReg, AddrErr;
    logic [15:0] Imm16;
    logic [1:0]  ExtOp;

    int errors = 0;
    int checks = 0;

    ifetch_unit_if bus ();

    always #5 clk = ~clk;

    ifetch_unit #(.RESET_PC(32'h0000_3000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (bus),
        .Instr       (Instr),
        .InstrValid  (InstrValid),
        .PC          (PC),
        .PCPlus4     (PCPlus4),
        .Imm16       (Imm16),
        .ExtOp       (ExtOp),
        .ExDone      (ExDone),
        .BranchTaken (BranchTaken),
        .BranchOff   (BranchOff),
        .Jump        (Jump),
        .JumpReg     (JumpReg),
        .JrAddr      (JrAddr),
        .AddrErr     (AddrErr)
    );

    typedef struct {
        logic [31:0] instr;
        int          waits;
        logic        bt;
        logic [31:0] boff;
        logic        jmp;
        logic        jr;
        logic [31:0] jrAddr;
        logic [1:0]  expExt;
        logic [15:0] expImm;
        logic [31:0] expNext;
        logic        expErr;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clearCtl;
        ExDone      = 1'b0;
        BranchTaken = 1'b0;
        BranchOff   = '0;
        Jump        = 1'b0;
        JumpReg     = 1'b0;
        JrAddr      = '0;
    endtask

    initial begin
        logic [31:0] expPc;

        //            instr         w  bt  boff          j  jr jrAddr        ext    imm       next          err
        vecs[0]  = '{32'h3C01_ABCD, 0, 0, 32'h0,        0, 0, 32'h0,        2'b10, 16'hABCD, 32'h0000_3008, 0};
        vecs[1]  = '{32'h8C22_FFFC, 2, 1, 32'hFFFF_FFFE, 0, 0, 32'h0,        2'b01, 16'hFFFC, 32'h0000_3004, 0};
        vecs[2]  = '{32'h3000_0001, 0, 0, 32'h0,        0, 0, 32'h0,        2'b00, 16'h0001, 32'h0000_3008, 0};
        vecs[3]  = '{32'h38A5_5A5A, 1, 0, 32'hFFFF_FFFE, 0, 0, 32'h0,        2'b00, 16'h5A5A, 32'h0000_300C, 0};
        vecs[4]  = '{32'h0800_0C10, 0, 1, 32'h4,        1, 0, 32'h0,        2'b01, 16'h0C10, 32'h0000_3040, 0};
        vecs[5]  = '{32'h0000_0008, 0, 0, 32'h0,        1, 1, 32'h0000_3042, 2'b01, 16'h0008, 32'h0000_3040, 1};
        vecs[6]  = '{32'h4000_0000, 0, 0, 32'h0,        0, 1, 32'h0000_5000, 2'b01, 16'h0000, 32'h0000_5000, 0};
        vecs[7]  = '{32'h1000_0010, 3, 1, 32'h10,       0, 0, 32'h0,        2'b01, 16'h0010, 32'h0000_5044, 0};
        vecs[8]  = '{32'h3C00_0000, 0, 0, 32'h0,        0, 1, 32'hFFFF_FFFC, 2'b10, 16'h0000, 32'hFFFF_FFFC, 0};
        vecs[9]  = '{32'h3400_0000, 0, 0, 32'h0,        0, 0, 32'h0,        2'b00, 16'h0000, 32'h0000_0000, 0};
        vecs[10] = '{32'h0BFF_FFFF, 0, 0, 32'h0,        1, 0, 32'h0,        2'b01, 16'hFFFF, 32'h0FFF_FFFC, 0};
        vecs[11] = '{32'h1000_0001, 0, 1, 32'h4000_0001, 0, 0, 32'h0,        2'b01, 16'h0001, 32'h1000_0004, 0};

        rst_n = 1'b0;
        bus.ImemRvalid = 1'b0;
        bus.ImemRdata  = '0;
        clearCtl();

        // Reset and first fetch
        repeat (3) tick();
        chk("rst PC", PC, 32'h3000);
        chk("rst Instr", Instr, 32'h0);
        chk("rst InstrValid", InstrValid, 0);
        chk("rst ImemReq", bus.ImemReq, 0);
        chk("rst AddrErr", AddrErr, 0);
        rst_n = 1'b1;
        chk("RST ImemReq", bus.ImemReq, 0);
        tick();
        chk("first fetch ImemReq", bus.ImemReq, 1);
        chk("first fetch ImemAddr", bus.ImemAddr, 32'h3000);

        // Wait-state fetch: address must hold until rvalid
        for (int w = 0; w < 3; w++) begin
            chk("wait ImemAddr", bus.ImemAddr, 32'h3000);
            chk("wait ImemReq", bus.ImemReq, 1);
            chk("wait InstrValid", InstrValid, 0);
            tick();
        end
        bus.ImemRvalid = 1'b1;
        bus.ImemRdata  = 32'h3408_1234;
        tick();
        bus.ImemRvalid = 1'b0;
        chk("ori Instr", Instr, 32'h3408_1234);
        chk("ori InstrValid", InstrValid, 1);
        chk("ori Imm16", Imm16, 16'h1234);
        chk("ori ExtOp", ExtOp, 2'b00);
        chk("hold ImemReq", bus.ImemReq, 0);

        // Spurious rvalid during HOLD
        bus.ImemRvalid = 1'b1;
        bus.ImemRdata  = 32'hDEAD_BEEF;
        repeat (2) tick();
        bus.ImemRvalid = 1'b0;
        chk("spurious rvalid Instr", Instr, 32'h3408_1234);
        chk("spurious rvalid InstrValid", InstrValid, 1);
        chk("spurious rvalid ImemReq", bus.ImemReq, 0);
        chk("spurious rvalid PC", PC, 32'h3000);

        ExDone = 1'b1;
        tick();
        ExDone = 1'b0;
        chk("seq ImemAddr", bus.ImemAddr, 32'h3004);
        chk("seq InstrValid", InstrValid, 0);

        // Spurious ExDone during FETCH
        ExDone = 1'b1;
        BranchTaken = 1'b1;
        BranchOff = 32'h100;
        repeat (2) tick();
        clearCtl();
        chk("spurious exdone PC", PC, 32'h3004);
        chk("spurious exdone ImemReq", bus.ImemReq, 1);
        chk("spurious exdone InstrValid", InstrValid, 0);
        chk("spurious exdone Instr", Instr, 32'h3408_1234);

        // Table: decode plus next-PC selection
        expPc = 32'h3004;
        for (int i = 0; i < 12; i++) begin
            for (int w = 0; w < vecs[i].waits; w++) begin
                chk($sformatf("v%0d wait ImemAddr", i), bus.ImemAddr, expPc);
                tick();
            end
            bus.ImemRvalid = 1'b1;
            bus.ImemRdata  = vecs[i].instr;
            tick();
            bus.ImemRvalid = 1'b0;
            chk($sformatf("v%0d Instr", i), Instr, vecs[i].instr);
            chk($sformatf("v%0d InstrValid", i), InstrValid, 1);
            chk($sformatf("v%0d ExtOp", i), ExtOp, vecs[i].expExt);
            chk($sformatf("v%0d Imm16", i), Imm16, vecs[i].expImm);
            chk($sformatf("v%0d PC", i), PC, expPc);
            chk($sformatf("v%0d PCPlus4", i), PCPlus4, expPc + 32'd4);

            BranchTaken = vecs[i].bt;
            BranchOff   = vecs[i].boff;
            Jump        = vecs[i].jmp;
            JumpReg     = vecs[i].jr;
            JrAddr      = vecs[i].jrAddr;
            ExDone      = 1'b1;
            tick();
            clearCtl();
            chk($sformatf("v%0d next ImemAddr", i), bus.ImemAddr, vecs[i].expNext);
            chk($sformatf("v%0d next ImemReq", i), bus.ImemReq, 1);
            chk($sformatf("v%0d next InstrValid", i), InstrValid, 0);
            chk($sformatf("v%0d AddrErr", i), AddrErr, vecs[i].expErr);
            tick();
            chk($sformatf("v%0d AddrErr clear", i), AddrErr, 0);
            chk($sformatf("v%0d ImemAddr stable", i), bus.ImemAddr, vecs[i].expNext);
            expPc = vecs[i].expNext;
        end

        // Reset mid-fetch with a late rvalid
        rst_n = 1'b0;
        tick();
        chk("midrst PC", PC, 32'h3000);
        chk("midrst ImemReq", bus.ImemReq, 0);
        chk("midrst InstrValid", InstrValid, 0);
        bus.ImemRvalid = 1'b1;
        bus.ImemRdata  = 32'h3C01_1111;
        tick();
        chk("midrst Instr", Instr, 32'h0);
        chk("midrst InstrValid2", InstrValid, 0);
        rst_n = 1'b1;
        tick();
        chk("midrst restart ImemReq", bus.ImemReq, 1);
        chk("midrst restart ImemAddr", bus.ImemAddr, 32'h3000);
        chk("midrst restart InstrValid", InstrValid, 0);
        chk("midrst restart Instr", Instr, 32'h0);
        // Zero-wait fetch: rvalid already high in the first FETCH cycle
        tick();
        bus.ImemRvalid = 1'b0;
        chk("zero-wait Instr", Instr, 32'h3C01_1111);
        chk("zero-wait InstrValid", InstrValid, 1);
        chk("zero-wait ExtOp", ExtOp, 2'b10);
        chk("zero-wait PC", PC, 32'h3000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch stage of the CPU. Holds the PC, fetches one instruction at a time from instruction memory over a valid/ready handshake, and holds it in an instruction register.
- Sits directly upstream of the immediate extender. It drives Imm16 and a decoded 2-bit ExtOp into the extender.
- Sits directly downstream of the extender for branches. It takes the sign-extended offset (BranchOff) back in and computes the next PC.
- The execute side signals completion with ExDone.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset; must be word aligned.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ImemReq  out  1  fetch request.
- ImemAddr  out  32  fetch address; equals PC.
- ImemRdata  in  32  instruction word.
- ImemRvalid  in  1  ImemRdata valid.
- Instr  out  32  instruction register.
- InstrValid  out  1  Instr holds a fetched, unconsumed instruction.
- PC  out  32  address of Instr.
- PCPlus4  out  32  PC+4.
- Imm16  out  16  Instr[15:0], to extender DataIn.
- ExtOp  out  2  extension mode, to extender.
- ExDone  in  1  execute finished current Instr; apply next PC.
- BranchTaken  in  1  conditional branch taken.
- BranchOff  in  32  sign-extended offset from extender.
- Jump  in  1  j/jal.
- JumpReg  in  1  jr.
- JrAddr  in  32  jr target.
- AddrErr  out  1  one-cycle pulse on misaligned JrAddr.

Behaviour:
- Reset: when rst_n=0 at a rising edge, the next state is RST.
  - PC=RESET_PC.
  - Instr=0, InstrValid=0, ImemReq=0, AddrErr=0.
  - Reset asserted in any state aborts that state; a pending ImemRvalid is ignored.
- States: RST -> FETCH -> HOLD -> FETCH ...
- RST: lasts exactly one cycle after rst_n returns to 1, then goes to FETCH.
- FETCH:
  - ImemReq=1 and ImemAddr=PC, held stable until ImemRvalid=1 is sampled.
  - ImemRvalid may arrive in the first FETCH cycle (combinational memory) or any later cycle.
  - On the rvalid edge: Instr<=ImemRdata, then go to HOLD. At most one fetch is outstanding.
- HOLD:
  - ImemReq=0, InstrValid=1.
  - Stays in HOLD while ExDone=0.
  - On ExDone=1: PC<=NextPC, InstrValid<=0, then go to FETCH.
- Ignored inputs: ExDone outside HOLD; ImemRvalid outside FETCH.
- Latency: with 0-wait memory, each instruction takes 2 cycles (FETCH, HOLD) plus ExDone delay.
- NextPC, priority order (sampled only with ExDone):
  - JumpReg: {JrAddr[31:2],2'b00}; AddrErr=1 for one cycle if JrAddr[1:0]!=0.
  - else Jump: {PCPlus4[31:28], Instr[25:0], 2'b00}.
  - else BranchTaken: PCPlus4 + {BranchOff[29:0],2'b00}.
  - else PCPlus4.
- Arithmetic: all 32-bit modulo, wrap at 2^32 with no flag.
- Combinational outputs:
  - PCPlus4=PC+4.
  - Imm16=Instr[15:0].
  - ExtOp decoded from Instr[31:26]:
    - 0x0C/0x0D/0x0E (andi/ori/xori) -> 2'b00 zero.
    - 0x0F (lui) -> 2'b10 high.
    - all others -> 2'b01 signed.
  - ExtOp value 2'b11 is never produced.

Decomposition:
- Shared package cpu_pkg:
  - EXT_ZERO/EXT_SIGNED/EXT_HIGHPOS constants.
  - Opcode constants OP_ANDI, OP_ORI, OP_XORI, OP_LUI.
  - State enum ifu_state_t.
  - RESET_PC default.
- One natural sub-module: next_pc_logic, purely combinational NextPC mux/adders plus AddrErr detect.
- FSM, PC register and instruction register live in ifetch_unit.

Test Plan:
- Reset and first fetch: hold rst_n=0 for 3 cycles, then release.
  - PC=0x3000, ImemReq=0 for one cycle, then ImemReq=1 with ImemAddr=0x3000.
- Fetch with wait states: ImemRvalid delayed 3 cycles with ImemRdata=0x3408_1234 (ori).
  - ImemAddr stays stable throughout.
  - Then Instr=0x34081234, InstrValid=1, Imm16=0x1234, ExtOp=00.
  - lui 0x3C01_ABCD gives ExtOp=10; lw 0x8C22_FFFC gives ExtOp=01.
- Backward branch: PC=0x3008, BranchTaken=1, BranchOff=0xFFFF_FFFE, ExDone=1.
  - Next ImemAddr=0x3004.
  - With BranchTaken=0: next ImemAddr=0x300C.
- Jump priority: Instr=0x0800_0C10, Jump=1, BranchTaken=1.
  - Next PC=0x0000_3040 (Jump wins).
  - JumpReg=1 with JrAddr=0x0000_3042: PC=0x3040 and AddrErr pulses exactly 1 cycle.
- Reset mid-fetch: rst_n=0 while in FETCH, then ImemRvalid=1 one cycle later.
  - Rvalid is ignored; PC=0x3000, InstrValid=0; the fetch restarts after RST.
- Spurious inputs: ExDone=1 during FETCH and ImemRvalid=1 during HOLD.
  - No change to PC, Instr or state.
